// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC-V load/store path.
//   - funct3 width/sign codes for loads and stores
//   - lsu_state_t: load/store unit sequencer states
//   - STRB_W / XLEN: byte-enable and data widths of the data-memory port
//   - lsu_legal(): decides whether a requested access may go to the bus
package brisc_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RSP,
    LSU_DONE
  } lsu_state_t;

  // Exactly one of rd/wr, a known width code (unsigned codes are loads
  // only), and natural alignment for halfwords and words.
  function automatic logic lsu_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      unique case (f3)
        F3_B:    ok = 1'b1;
        F3_BU:   ok = rd;
        F3_H:    ok = ~off[0];
        F3_HU:   ok = rd & ~off[0];
        F3_W:    ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Data-memory port of the load/store unit: a valid/ready request channel
// and a valid-only load response channel.
//   master: LSU side (drives requests, receives responses)
//   slave : memory side
interface lsu_unit_if;
  import brisc_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [STRB_W-1:0] mem_req_strb;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_strb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_strb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
//   st_f3/st_off/st_data -> st_wdata (lane-replicated), st_strb (byte enables)
//   ld_f3/ld_off/ld_word -> ld_data (selected lane, sign/zero extended)
module lsu_align
  import brisc_pkg::*;
(
  input  logic [2:0]        st_f3,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata,
  output logic [STRB_W-1:0] st_strb,
  input  logic [2:0]        ld_f3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_word,
  output logic [XLEN-1:0]   ld_data
);

  logic [XLEN-1:0] ld_shift;

  // Replicating the store data lets memory pick whichever lane the strobe
  // enables without knowing the offset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_wdata = st_data;
    st_strb  = '0;
    unique case (st_f3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_strb  = STRB_W'(4'b0001) << st_off;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_strb  = STRB_W'(4'b0011) << st_off;
      end
      F3_W:    st_strb = '1;
      default: st_strb = '0;
    endcase
  end

  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    ld_data  = ld_word;
    unique case (ld_f3)
      F3_B:    ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
      F3_BU:   ld_data = {24'h0,              ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data = {16'h0,              ld_shift[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit between the ALU and the data-memory port.
//   clk, rst_n              : clock, asynchronous active-low reset
//   Start/MemRead/MemWrite  : one-cycle request from EX (taken only in IDLE)
//   funct3, Addr, WriteData : width code, effective address, store data
//   Busy, Done, Fault       : stall, completion pulse, fault flag (with Done)
//   ReadData                : extended load data, held until the next load
//   mem                     : data-memory port (lsu_unit_if.master)
// Optional feature macro: LSU_TIMEOUT_EN abandons a load after
// TIMEOUT_CYCLES cycles without a response and reports a fault.
module lsu_unit
  import brisc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic            Busy,
  output logic            Done,
  output logic            Fault,
  output logic [XLEN-1:0] ReadData,
  lsu_unit_if.master      mem
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [XLEN-1:0]   st_wdata, ld_data;
  logic [STRB_W-1:0] st_strb;

`ifdef LSU_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`else
  logic [TMO_W-1:0]  tmo_cfg_unused;
  assign tmo_cfg_unused = TMO_W'(TIMEOUT_CYCLES);
`endif

  // Store lanes come from the live inputs (registered at accept); load
  // extraction uses the latched offset/width against the response word.
  lsu_align u_align (
    .st_f3   (funct3),
    .st_off  (Addr[1:0]),
    .st_data (WriteData),
    .st_wdata(st_wdata),
    .st_strb (st_strb),
    .ld_f3   (f3_q),
    .ld_off  (off_q),
    .ld_word (mem.mem_rsp_rdata),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    fault_d = fault_q;
    off_d   = off_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      LSU_IDLE: begin
        if (Start) begin
          off_d = Addr[1:0];
          f3_d  = funct3;
          if (lsu_legal(MemRead, MemWrite, funct3, Addr[1:0])) begin
            // Bus fields only move for legal accesses: a fault never
            // disturbs the port.
            we_d    = MemWrite;
            addr_d  = {Addr[XLEN-1:2], 2'b00};
            wdata_d = st_wdata;
            strb_d  = st_strb;
            fault_d = 1'b0;
            state_d = LSU_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = LSU_DONE;
          end
        end
      end
      LSU_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = we_q ? LSU_DONE : LSU_WAIT_RSP;
`ifdef LSU_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      LSU_WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          rdata_d = ld_data;
          state_d = LSU_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = LSU_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, regardless of statement order.
      state_q <= state_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign Busy              = (state_q == LSU_REQ) || (state_q == LSU_WAIT_RSP);
  assign Done              = (state_q == LSU_DONE);
  assign Fault             = Done && fault_q;
  assign ReadData          = rdata_q;
  assign mem.mem_req_valid = (state_q == LSU_REQ);
  assign mem.mem_req_we    = we_q;
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_strb  = strb_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized
// loads/stores against a behavioural model of alignment, lanes and latency.
module tb_lsu_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic        Busy, Done, Fault;
  logic [31:0] ReadData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_exp = '0;

  lsu_unit_if mem_if ();

  lsu_unit #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .funct3   (funct3),
    .Addr     (Addr),
    .WriteData(WriteData),
    .Busy     (Busy),
    .Done     (Done),
    .Fault    (Fault),
    .ReadData (ReadData),
    .mem      (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes, 0 for an encoding that cannot be issued.
  function automatic int ref_size(input bit rd, input bit wr, input logic [2:0] f3);
    if (rd == wr) return 0;
    case (f3)
      3'b000:         return 1;
      3'b001:         return 2;
      3'b010:         return 4;
      3'b100, 3'b101: return rd ? ((f3 == 3'b100) ? 1 : 2) : 0;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    int sz;
    sz = ref_size(rd, wr, f3);
    return (sz != 0) && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] ref_strb(input int sz, input logic [31:0] a);
    logic [3:0] m;
    m = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    o = a % 4;
    b = w[8*o +: 8];
    h = (o <= 2) ? w[8*o +: 16] : 16'h0;
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'h0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Caller is at a negedge with the unit idle. rsp_dly < 0: never respond.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                       input int rdy_dly, input int rsp_dly, input bit spur);
    bit legal, done_seen, tmo_case;
    int acc, exp_done, sz;
    legal    = ref_legal(rd, wr, f3, a);
    sz       = ref_size(rd, wr, f3);
    tmo_case = legal && !wr && (rsp_dly < 0);
    acc = -1; exp_done = legal ? 999 : 1; done_seen = 0;
    Start = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; Addr = a; WriteData = wd;
    mem_if.mem_rsp_rdata = rw;
    @(negedge clk);
    for (int k = 1; k <= 64; k++) begin
      Start = spur && (k == 2);
      if (spur && k == 2) begin
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b000; Addr = 32'hDEAD_BEEF;
      end
      check("done_timing", {31'h0, Done}, {31'h0, k == exp_done});
      check("busy", {31'h0, Busy}, {31'h0, legal && (k < exp_done)});
      if (mem_if.mem_req_valid) begin
        if (!legal) check("bus_on_fault", 32'h1, 32'h0);
        else begin
          check("req_addr", mem_if.mem_req_addr, {a[31:2], 2'b00});
          check("req_we", {31'h0, mem_if.mem_req_we}, {31'h0, wr});
          if (wr) begin
            check("req_strb", {28'h0, mem_if.mem_req_strb}, {28'h0, ref_strb(sz, a)});
            check("req_wdata", mem_if.mem_req_wdata, ref_wdata(sz, wd));
          end
        end
      end
      if (Done) begin
        done_seen = 1;
        if (legal && !wr && !tmo_case) rd_exp = ref_load(f3, a, rw);
        check("fault", {31'h0, Fault}, {31'h0, !legal || tmo_case});
        check("read_data", ReadData, rd_exp);
        break;
      end
      mem_if.mem_req_ready = (k - 1 >= rdy_dly);
      if (mem_if.mem_req_valid && mem_if.mem_req_ready && acc < 0) begin
        acc = k;
        exp_done = wr ? k + 1 : (rsp_dly < 0) ? k + 1 + TMO : k + 2 + rsp_dly;
      end
      mem_if.mem_rsp_valid = !wr && (acc > 0) && (rsp_dly >= 0) && (k == acc + 1 + rsp_dly);
      @(negedge clk);
    end
    if (!done_seen) check("done_never_seen", 32'h0, 32'h1);
    Start = 1'b0; mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'h0, Done}, 32'h0);
  endtask

  logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b010, 3'b011};

  initial begin
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    #12;
    check("rst_busy", {31'h0, Busy}, 32'h0);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_valid", {31'h0, mem_if.mem_req_valid}, 32'h0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_strb", {28'h0, mem_if.mem_req_strb}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    do_op(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    do_op(1, 0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 0);
    check("lb_value", ReadData, 32'hFFFF_FF80);
    do_op(1, 0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 0);
    check("lbu_value", ReadData, 32'h0000_0080);
    do_op(1, 0, 3'b001, 32'h0000_2002, 32'h0, 32'h8000_1234, 0, 0, 0);
    check("lh_value", ReadData, 32'hFFFF_8000);
    do_op(1, 0, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 0, 0, 0);
    do_op(0, 1, 3'b010, 32'h0000_4008, 32'hCAFE_F00D, 32'h0, 5, 0, 1);
    do_op(1, 1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 0);
    do_op(0, 1, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 0);

    // Reset while waiting for a load response.
    Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; Addr = 32'h0000_3000;
    @(negedge clk);
    Start = 1'b0; mem_if.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_if.mem_req_ready = 1'b0;
    check("wait_busy", {31'h0, Busy}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, Busy}, 32'h0);
    check("mid_rst_valid", {31'h0, mem_if.mem_req_valid}, 32'h0);
    check("mid_rst_done", {31'h0, Done}, 32'h0);
    check("mid_rst_readdata", ReadData, 32'h0);
    check("mid_rst_addr", mem_if.mem_req_addr, 32'h0);
    rd_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_if.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_rsp_done", {31'h0, Done}, 32'h0);
      check("stray_rsp_data", ReadData, 32'h0);
      @(negedge clk);
    end
    do_op(1, 0, 3'b010, 32'h0000_3004, 32'h0, 32'h1357_9BDF, 1, 2, 0);
    check("lw_after_rst", ReadData, 32'h1357_9BDF);

`ifdef LSU_TIMEOUT_EN
    do_op(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0BAD_0BAD, 0, -1, 0);
    check("tmo_keeps_data", ReadData, 32'h1357_9BDF);
`endif

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      int  sel;
      bit  rd, wr;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin rd = $urandom_range(0, 1); wr = rd; end
      else begin rd = (sel < 5); wr = !rd; end
      do_op(rd, wr, f3_tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Load/store unit directly downstream of the ALU in the BRISC-V datapath. It takes the ALU's effective address plus rs2 data and the load/store funct3, and runs a valid/ready transaction on the data-memory port. It returns sign- or zero-extended load data to writeback and raises Busy so the core stalls while an access is outstanding. Illegal encodings and misaligned addresses become a fault instead of a bus request.

Parameters:
TIMEOUT_CYCLES, 255, cycles in WAIT_RSP before a load is abandoned (only used with LSU_TIMEOUT_EN)
TMO_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle request from EX; sampled only when Busy=0
MemRead  input  1  load request
MemWrite  input  1  store request
funct3  input  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
Addr  input  32  effective address (ALUResult)
WriteData  input  32  store data (rs2)
Busy  output  1  high from the cycle after Start accept until Done
Done  output  1  one-cycle completion pulse
Fault  output  1  valid with Done: misaligned, illegal, or timeout
ReadData  output  32  extended load data; held until next Done
mem_req_valid  output  1  bus request valid
mem_req_ready  input  1  bus accepts request
mem_req_we  output  1  1 = store
mem_req_addr  output  32  word address {Addr[31:2],2'b00}
mem_req_wdata  output  32  lane-replicated store data
mem_req_strb  output  4  byte enables
mem_rsp_valid  input  1  load data valid
mem_rsp_rdata  input  32  load word

Behaviour:
- Reset (async, rst_n=0): state IDLE. Busy, Done, Fault, mem_req_valid and mem_req_we are 0. ReadData, addr, wdata and strb are 0. Reset mid-transaction drops mem_req_valid immediately and abandons the access; no Done is produced.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - Start=1 latches Addr, funct3, WriteData and the op.
  - Legal access -> REQ.
  - Illegal access -> DONE with Fault=1 and no bus activity. Illegal means: both MemRead and MemWrite set; neither set; funct3 not in the legal set (stores additionally reject 100/101); half with Addr[0]=1; word with Addr[1:0]!=0.
  - Start while Busy=1 is ignored.
- REQ: mem_req_valid=1, all request fields stable until mem_req_ready=1 in the same cycle.
  - Store accepted -> DONE.
  - Load accepted -> WAIT_RSP.
- WAIT_RSP: mem_rsp_valid=1 captures the extended rdata into ReadData -> DONE. mem_rsp_valid in any other state is ignored.
- DONE: Done=1 for exactly one cycle; Fault is valid this cycle -> IDLE. Busy=0 in DONE, so Start is accepted the cycle after Done.
- Latency (Start at cycle T):
  - Request valid at T+1.
  - Store accepted at cycle A -> Done at A+1 (minimum T+2).
  - Load response at cycle R -> Done at R+1 (minimum T+3).
  - Fault path: Done at T+1.
- Store lanes, with o=Addr[1:0]:
  - SB: strb=4'b0001<<o, wdata = byte replicated x4.
  - SH: strb=4'b0011<<o, wdata = half replicated x2.
  - SW: strb=4'b1111.
- Load extract, with o=Addr[1:0]:
  - Byte lane: rdata[8o+7:8o], sign-extended (B) or zero-extended (BU).
  - Half lane: rdata[8o+15:8o], sign-extended (H) or zero-extended (HU).
  - W: full word.
- ReadData is unchanged by stores and faults.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on WAIT_RSP entry and increments each cycle without mem_rsp_valid. Reaching TIMEOUT_CYCLES -> DONE with Fault=1 and ReadData unchanged; a later stray response is ignored.
- Undefined: no counter; WAIT_RSP waits indefinitely.

Decomposition:
- Shared package brisc_pkg:
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum.
  - Strobe widths.
- One natural sub-module, lsu_align: combinational store lane/strobe generation and load extract/extend, instantiated by lsu_unit.

Test Plan:
- SB Addr=0x1003, WriteData=0x000000A5, ready=1 at once -> addr=0x1000, strb=1000, wdata=0xA5A5A5A5, Done at T+2, Fault=0.
- LB Addr=0x2001, rdata=0x12348056 one cycle after accept -> ReadData=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH Addr=0x2002, rdata=0x80001234 -> ReadData=0xFFFF8000. LW Addr=0x2002 -> no mem_req_valid, Done at T+1, Fault=1.
- SW with mem_req_ready held low 5 cycles -> valid, addr and wdata stable throughout; Done 1 cycle after accept. A second Start during Busy is ignored.
- rst_n pulsed low while in WAIT_RSP -> outputs 0 immediately, no Done. A late mem_rsp_valid is ignored, and the next LW completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response -> Done with Fault=1 after 4 WAIT_RSP cycles; ReadData retains its previous value.
